// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: clears x1..x(2**AW-1) after reset, then round-robin
// arbitrates ALU (req0) and load (req1) writebacks onto a registered A3/WD3/WE3.
module rf_wb_arbiter #(
  parameter int               XLEN           = 32,
  parameter int               AW             = 5,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [XLEN-1:0]  CLEAR_VAL      = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic [1:0]      grant,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  output logic            we3,
  output logic            init_done
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            last1_q, last1_d;
  logic            init_q, init_d;
  logic            we_p1, we_d;
  logic [AW-1:0]   wa_p1, wa_d;
  logic [XLEN-1:0] wd_p1, wd_d;
  logic [1:0]      grant_p1, grant_d;
  logic            pick1;
  logic            rdy0, rdy1;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  // req1 wins when alone, or when both ask and req0 was granted last
  assign pick1    = req1_valid & (~req0_valid | ~last1_q);
  assign sel_addr = pick1 ? req1_addr : req0_addr;
  assign sel_data = pick1 ? req1_data : req0_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last1_d = last1_q;
    init_d  = init_q;
    we_d    = 1'b0;
    wa_d    = wa_p1;
    wd_d    = wd_p1;
    grant_d = 2'b00;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        // counter wraps to zero after issuing the top register: clear is complete
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          init_d  = 1'b1;
        end else begin
          we_d  = 1'b1;
          wa_d  = cnt_q;
          wd_d  = CLEAR_VAL;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        init_d = 1'b1;
        rdy1   = pick1;
        rdy0   = req0_valid & ~pick1;
        if (rdy0 | rdy1) begin
          grant_d = {rdy1, rdy0};
          wa_d    = sel_addr;
          wd_d    = sel_data;
          we_d    = |sel_addr;
          last1_d = rdy1;
        end
      end
      default: ;
    endcase
  end

  // stage p1: registered write port toward reg_file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RST;
      cnt_q    <= {{(AW-1){1'b0}}, 1'b1};
      last1_q  <= 1'b1;
      init_q   <= 1'b0;
      we_p1    <= 1'b0;
      wa_p1    <= '0;
      wd_p1    <= '0;
      grant_p1 <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last1_q  <= last1_d;
      init_q   <= init_d;
      we_p1    <= we_d;
      wa_p1    <= wa_d;
      wd_p1    <= wd_d;
      grant_p1 <= grant_d;
    end
  end

  assign req0_ready = rdy0;
  assign req1_ready = rdy1;
  assign grant      = grant_p1;
  assign wa3        = wa_p1;
  assign wd3        = wd_p1;
  assign we3        = we_p1;
  assign init_done  = init_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: scoreboard of expected write-port beats plus a
// shadow register file fed from the write port.
module tb_rf_wb_arbiter;
  localparam int          XLEN = 32;
  localparam int          AW   = 5;
  localparam logic [31:0] CV   = 32'h0;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            we;
    logic [1:0]      g;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0]   req0_addr, req1_addr, wa3;
  logic [XLEN-1:0] req0_data, req1_data, wd3;
  logic [1:0]      grant;
  logic            we3, init_done;

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .grant(grant), .wa3(wa3), .wd3(wd3), .we3(we3), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              passed = 0;
  exp_t            q[$];
  logic [1:0]      hist[$];
  logic [XLEN-1:0] tb_rf[32];
  bit              tb_run, tb_init, tb_last1;
  logic [AW-1:0]   tb_cnt, tb_last_wa;
  logic [XLEN-1:0] tb_last_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    q.delete();
    tb_cnt     = 5'd1;
    tb_run     = 1'b0;
    tb_init    = 1'b0;
    tb_last1   = 1'b1;
    tb_last_wa = '0;
    tb_last_wd = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we3"}, 64'(we3), 64'h0);
    chk({tag, "_wa3"}, 64'(wa3), 64'h0);
    chk({tag, "_wd3"}, 64'(wd3), 64'h0);
    chk({tag, "_grant"}, 64'(grant), 64'h0);
    chk({tag, "_init_done"}, 64'(init_done), 64'h0);
    chk({tag, "_req0_ready"}, 64'(req0_ready), 64'h0);
    chk({tag, "_req1_ready"}, 64'(req1_ready), 64'h0);
  endtask

  // one clock: check this cycle's outputs and readys, queue the beat expected next cycle
  task automatic cycle();
    exp_t e;
    logic er0, er1;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("we3", 64'(we3), 64'(e.we));
      chk("wa3", 64'(wa3), 64'(e.a));
      chk("wd3", 64'(wd3), 64'(e.d));
      chk("grant", 64'(grant), 64'(e.g));
      tb_last_wa = e.a;
      tb_last_wd = e.d;
    end else begin
      chk("idle_we3", 64'(we3), 64'h0);
      chk("idle_grant", 64'(grant), 64'h0);
      chk("hold_wa3", 64'(wa3), 64'(tb_last_wa));
      chk("hold_wd3", 64'(wd3), 64'(tb_last_wd));
    end
    if (grant != 2'b00) hist.push_back(grant);
    if (we3 === 1'b1) tb_rf[wa3] = wd3;
    chk("init_done", 64'(init_done), 64'(tb_init));
    er0 = 1'b0;
    er1 = 1'b0;
    if (tb_run) begin
      er1 = req1_valid && (!req0_valid || !tb_last1);
      er0 = req0_valid && !er1;
    end
    chk("req0_ready", 64'(req0_ready), 64'(er0));
    chk("req1_ready", 64'(req1_ready), 64'(er1));
    if (!tb_run) begin
      if (tb_cnt != '0) begin
        q.push_back('{a: tb_cnt, d: CV, we: 1'b1, g: 2'b00});
        tb_cnt = tb_cnt + 1'b1;
      end else begin
        tb_run  = 1'b1;
        tb_init = 1'b1;
      end
    end else if (er0 || er1) begin
      e.a  = er1 ? req1_addr : req0_addr;
      e.d  = er1 ? req1_data : req0_data;
      e.we = (e.a != '0);
      e.g  = {er1, er0};
      q.push_back(e);
      tb_last1 = er1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tb_rf[i] = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    // clear sequence with req0 knocking; readys must stay low until RUN
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h5;
    rst_n = 1'b1;
    repeat (20) cycle();
    req0_valid = 1'b0;
    repeat (13) cycle();
    chk("clear_init_done", 64'(init_done), 64'h1);
    chk("clear_x31", 64'(tb_rf[31]), 64'(CV));
    chk("clear_x1", 64'(tb_rf[1]), 64'(CV));

    // single ALU writeback
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    cycle();
    req0_valid = 1'b0;
    cycle(); cycle();
    chk("x5_value", 64'(tb_rf[5]), 64'hDEAD_BEEF);

    // lone load writeback so req1 is the last grant
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    cycle();
    req1_valid = 1'b0;
    cycle();
    hist.delete();

    // both held for four cycles: strict alternation starting with req0
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
    repeat (4) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(); cycle();
    chk("alt_count", 64'(hist.size()), 64'd4);
    if (hist.size() == 4) begin
      chk("alt_g0", 64'(hist[0]), 64'h1);
      chk("alt_g1", 64'(hist[1]), 64'h2);
      chk("alt_g2", 64'(hist[2]), 64'h1);
      chk("alt_g3", 64'(hist[3]), 64'h2);
    end
    chk("x3_value", 64'(tb_rf[3]), 64'h11);
    chk("x4_value", 64'(tb_rf[4]), 64'h22);

    // same destination from both: req0 first, req1 last
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
    cycle();
    req0_valid = 1'b0;
    cycle();
    req1_valid = 1'b0;
    chk("x7_first", 64'(tb_rf[7]), 64'hA);
    cycle(); cycle();
    chk("x7_final", 64'(tb_rf[7]), 64'hB);

    // write to x0 is accepted but never enabled
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
    cycle();
    req1_valid = 1'b0;
    cycle(); cycle();
    chk("x0_value", 64'(tb_rf[0]), 64'h0);

    // req1 loses then withdraws; pointer must still favour req1 next time
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h2;
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(); cycle();
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h3;
    req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'h4;
    #1;
    chk("rr_hold_req1_ready", 64'(req1_ready), 64'h1);
    chk("rr_hold_req0_ready", 64'(req0_ready), 64'h0);
    cycle();
    req1_valid = 1'b0;
    cycle();
    req0_valid = 1'b0;
    cycle(); cycle();
    chk("x11_untouched", 64'(tb_rf[11]), 64'(CV));
    chk("x12_value", 64'(tb_rf[12]), 64'h3);
    chk("x13_value", 64'(tb_rf[13]), 64'h4);

    // reset mid-clear: write abandoned at once, clear restarts from x1
    rst_n = 1'b0;
    #1;
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (9) cycle();
    chk("midclear_we3_before", 64'(we3), 64'h1);
    chk("midclear_wa3_before", 64'(wa3), 64'd9);
    rst_n = 1'b0;
    #1;
    check_reset("midclear");
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    rst_n = 1'b1;
    repeat (33) cycle();
    chk("reclear_init_done", 64'(init_done), 64'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
